// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//
// Shares a single-port data memory between two requesters. Port 0 is the
// CPU load/store stage and port 1 is the DMA/debug port. The winner is
// chosen round-robin, or with port 0 always first when FIXED_PRI = 1.
// Each transaction drives exactly one memory command cycle. The memory's
// registered read data is captured on the following cycle, and the winner
// then receives a one-cycle ack.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req0/1, we0/1        request and write-enable per port
//   addr0/1, wdata0/1    request address and write data per port
//   ack0/1               one-cycle completion pulse per port
//   rdata0/1             read result per port, held until the next read
//   busy                 high whenever the sequencer is not idle
//   mem_address          memory address (holds between transactions)
//   mem_write_data       memory write data
//   mem_read, mem_write  memory command strobes, one cycle per transaction
//   mem_read_data        registered memory read data
//   state_dbg            current sequencer state (IDLE=0 ISSUE=1 WAIT=2 DONE=3)
//
// Handshake: a requester raises req with we/addr/wdata stable and keeps
// them stable until it sees ack high, which lasts exactly one cycle. If req
// is still high on the cycle after ack, that is a new request. Requests
// are only looked at while the sequencer is IDLE.
module dmem_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int FIXED_PRI = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          busy,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_write_data,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_read_data,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic cmd_id;      // port that owns the current transaction
  logic cmd_we;      // current transaction is a write
  logic last;        // port served most recently
  logic grant_valid;
  logic grant_id;

  assign state_dbg = state;

  // On a tie, round-robin favours the port that was not served last.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (req0 && req1) begin
      grant_valid = 1'b1;
      grant_id    = (FIXED_PRI != 0) ? 1'b0 : ~last;
    end else if (req0) begin
      grant_valid = 1'b1;
      grant_id    = 1'b0;
    end else if (req1) begin
      grant_valid = 1'b1;
      grant_id    = 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_valid) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // All outputs are registers loaded one edge ahead of the state they
  // belong to. For example, the strobes are set on the IDLE->ISSUE edge,
  // so they are high during ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_id         <= 1'b0;
      cmd_we         <= 1'b0;
      last           <= 1'b1;
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      rdata0         <= '0;
      rdata1         <= '0;
      ack0           <= 1'b0;
      ack1           <= 1'b0;
      busy           <= 1'b0;
    end else begin
      busy      <= (state_next != IDLE);
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            cmd_id         <= grant_id;
            cmd_we         <= grant_id ? we1 : we0;
            mem_address    <= grant_id ? addr1 : addr0;
            mem_write_data <= grant_id ? wdata1 : wdata0;
            mem_write      <= grant_id ? we1 : we0;
            mem_read       <= grant_id ? ~we1 : ~we0;
          end
        end
        WAIT: begin
          // The memory presents the read result during WAIT.
          if (!cmd_we) begin
            if (cmd_id) rdata1 <= mem_read_data;
            else        rdata0 <= mem_read_data;
          end
          ack0 <= ~cmd_id;
          ack1 <= cmd_id;
        end
        DONE: begin
          last <= cmd_id;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: a round-robin instance (dut) and a
// fixed-priority instance (dut_fp) share stimulus, and each has its own
// memory model.
module tb_dmem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [7:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;

  logic       ack0, ack1, busy, mem_read, mem_write;
  logic [7:0] rdata0, rdata1, mem_address, mem_write_data, mrd;
  logic [1:0] state_dbg;

  logic       fp_ack0, fp_ack1, fp_busy, fp_mem_read, fp_mem_write;
  logic [7:0] fp_rdata0, fp_rdata1, fp_mem_address, fp_mem_write_data, fp_mrd;
  logic [1:0] fp_state;

  logic [7:0] mem    [256];
  logic [7:0] mem_fp [256];
  logic       pl_we = 1'b0;
  logic [7:0] pl_addr = '0, pl_data = '0;

  int n_checks = 0;
  int n_fail = 0;
  int rd_cycles = 0, wr_cycles = 0, ack_overlap = 0, strobe_overlap = 0;
  int cyc;
  int ack0_at[$];
  int ack1_at[$];
  int fp_n0, fp_n1;

  typedef struct {
    bit         port;
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;
  vec_t vecs[11];

  dmem_arbiter #(.AW(8), .DW(8), .FIXED_PRI(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mrd),
    .state_dbg(state_dbg)
  );

  dmem_arbiter #(.AW(8), .DW(8), .FIXED_PRI(1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(fp_ack0), .ack1(fp_ack1), .rdata0(fp_rdata0), .rdata1(fp_rdata1),
    .busy(fp_busy),
    .mem_address(fp_mem_address), .mem_write_data(fp_mem_write_data),
    .mem_read(fp_mem_read), .mem_write(fp_mem_write), .mem_read_data(fp_mrd),
    .state_dbg(fp_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory models (registered read) ----------------
  always @(posedge clk) begin
    if (pl_we) begin
      mem[pl_addr]    <= pl_data;
      mem_fp[pl_addr] <= pl_data;
    end
    if (mem_write)    mem[mem_address] <= mem_write_data;
    if (mem_read)     mrd <= mem[mem_address];
    if (fp_mem_write) mem_fp[fp_mem_address] <= fp_mem_write_data;
    if (fp_mem_read)  fp_mrd <= mem_fp[fp_mem_address];
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mem_read)             rd_cycles++;
    if (mem_write)            wr_cycles++;
    if (ack0 && ack1)         ack_overlap++;
    if (mem_read && mem_write) strobe_overlap++;
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_state"}, state_dbg, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ack"}, {ack0, ack1}, 0);
    chk({tag, "_strobes"}, {mem_read, mem_write}, 0);
    chk({tag, "_mem_address"}, mem_address, 0);
    chk({tag, "_mem_write_data"}, mem_write_data, 0);
    chk({tag, "_rdata0"}, rdata0, 0);
    chk({tag, "_rdata1"}, rdata1, 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    #1 check_reset_values("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_we = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic drive(input bit port, input bit we, input logic [7:0] a, input logic [7:0] d);
    if (port) begin
      req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
    end else begin
      req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
    end
  endtask

  // One isolated transaction, checking timing, strobes and result.
  task automatic do_txn(input bit port, input bit we, input logic [7:0] a,
                        input logic [7:0] d, input logic [7:0] exp_rd);
    int r0, w0, at;
    r0 = rd_cycles;
    w0 = wr_cycles;
    at = 0;
    @(negedge clk);
    drive(port, we, a, d);
    for (int c = 1; c <= 10 && at == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("issue_addr", mem_address, a);
        chk("issue_strobe", {mem_write, mem_read}, we ? 2 : 1);
        if (we) chk("issue_wdata", mem_write_data, d);
      end
      if (port ? ack1 : ack0) begin
        at = c;
        chk("other_ack", port ? ack0 : ack1, 0);
        chk("rdata", port ? rdata1 : rdata0, exp_rd);
        if (port) req1 = 1'b0;
        else      req0 = 1'b0;
      end
    end
    chk("ack_latency", at, 3);
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    chk("busy_after", busy, 0);
    chk("state_after", state_dbg, 0);
    chk("rd_count", rd_cycles - r0, we ? 0 : 1);
    chk("wr_count", wr_cycles - w0, we ? 1 : 0);
  endtask

  // Runs n cycles, logging ack times; a port drops req after keepN acks.
  task automatic run_cycles(input int n, input int keep0, input int keep1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (ack0) begin
        ack0_at.push_back(cyc);
        if (ack0_at.size() >= keep0) req0 = 1'b0;
      end
      if (ack1) begin
        ack1_at.push_back(cyc);
        if (ack1_at.size() >= keep1) req1 = 1'b0;
      end
      if (fp_ack0) fp_n0++;
      if (fp_ack1) fp_n1++;
    end
  endtask

  task automatic clear_log();
    cyc = 0;
    ack0_at.delete();
    ack1_at.delete();
    fp_n0 = 0;
    fp_n1 = 0;
  endtask

  function automatic int at_or_0(input int q[$], input int i);
    return (i < q.size()) ? q[i] : 0;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    vecs[0]  = '{1'b1, 1'b0, 8'h10, 8'h00, 8'hA5};
    vecs[1]  = '{1'b0, 1'b1, 8'h20, 8'h3C, 8'h00};
    vecs[2]  = '{1'b0, 1'b0, 8'h20, 8'h00, 8'h3C};
    vecs[3]  = '{1'b1, 1'b1, 8'h21, 8'h55, 8'hA5};
    vecs[4]  = '{1'b1, 1'b0, 8'h21, 8'h00, 8'h55};
    vecs[5]  = '{1'b0, 1'b0, 8'h21, 8'h00, 8'h55};
    vecs[6]  = '{1'b1, 1'b0, 8'h20, 8'h00, 8'h3C};
    vecs[7]  = '{1'b0, 1'b1, 8'hFF, 8'h00, 8'h55};
    vecs[8]  = '{1'b0, 1'b0, 8'hFF, 8'h00, 8'h00};
    vecs[9]  = '{1'b1, 1'b1, 8'h00, 8'hFF, 8'h3C};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'hFF};

    // Reset held from time 0.
    repeat (2) @(negedge clk);
    check_reset_values("por");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_no_req_busy", busy, 0);
    chk("idle_no_req_state", state_dbg, 0);

    preload(8'h10, 8'hA5);

    // Table-driven single transactions.
    foreach (vecs[i])
      do_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);
    chk("rdata1_held", rdata1, 8'h3C);

    // Simultaneous requests right after reset: port 0 first.
    apply_reset();
    clear_log();
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h10, 8'h00);
    drive(1'b1, 1'b0, 8'h20, 8'h00);
    run_cycles(12, 1, 1);
    chk("sim_ack0_n", ack0_at.size(), 1);
    chk("sim_ack0_t", at_or_0(ack0_at, 0), 3);
    chk("sim_ack1_n", ack1_at.size(), 1);
    chk("sim_ack1_t", at_or_0(ack1_at, 0), 7);
    chk("sim_rdata0", rdata0, 8'hA5);
    chk("sim_rdata1", rdata1, 8'h3C);

    // Request raised while busy waits for IDLE.
    clear_log();
    @(negedge clk);
    drive(1'b1, 1'b0, 8'h21, 8'h00);
    run_cycles(1, 1, 1);
    drive(1'b0, 1'b0, 8'hFF, 8'h00);
    run_cycles(11, 1, 1);
    chk("late_ack1_t", at_or_0(ack1_at, 0), 3);
    chk("late_ack0_n", ack0_at.size(), 1);
    chk("late_ack0_t", at_or_0(ack0_at, 0), 7);
    chk("late_rdata0", rdata0, 8'h00);

    // req held through ack repeats the transaction.
    clear_log();
    begin
      int r0;
      r0 = rd_cycles;
      @(negedge clk);
      drive(1'b0, 1'b0, 8'h21, 8'h00);
      run_cycles(12, 2, 1);
      chk("held_ack0_n", ack0_at.size(), 2);
      chk("held_ack0_t0", at_or_0(ack0_at, 0), 3);
      chk("held_ack0_t1", at_or_0(ack0_at, 1), 7);
      chk("held_rd_count", rd_cycles - r0, 2);
      chk("held_rdata0", rdata0, 8'h55);
    end

    // Continuous contention for 8 transactions.
    apply_reset();
    clear_log();
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h10, 8'h00);
    drive(1'b1, 1'b0, 8'h20, 8'h00);
    run_cycles(32, 100, 100);
    req0 = 1'b0;
    req1 = 1'b0;
    chk("rr_ack0_n", ack0_at.size(), 4);
    chk("rr_ack1_n", ack1_at.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk("rr_ack0_t", at_or_0(ack0_at, k), 3 + 8 * k);
      chk("rr_ack1_t", at_or_0(ack1_at, k), 7 + 8 * k);
    end
    chk("fp_ack0_n", fp_n0, 8);
    chk("fp_ack1_n", fp_n1, 0);
    repeat (4) @(negedge clk);
    chk("rr_idle_after", busy, 0);

    // Reset during ISSUE of a write cancels it.
    preload(8'h05, 8'h11);
    @(negedge clk);
    drive(1'b0, 1'b1, 8'h05, 8'hFF);
    @(negedge clk);
    chk("mid_issue_write", mem_write, 1);
    rst_n = 1'b0;
    req0 = 1'b0;
    #1 check_reset_values("mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("mid_mem_unchanged", mem[8'h05], 8'h11);
    chk("mid_fp_mem_unchanged", mem_fp[8'h05], 8'h11);
    do_txn(1'b0, 1'b0, 8'h05, 8'h00, 8'h11);

    chk("ack_overlap_cycles", ack_overlap, 0);
    chk("strobe_overlap_cycles", strobe_overlap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
